bht_tagged_sat: RTL and testbench

- Parametrised successor to the single-bit valid/PC branch history table in the Ariane frontend.
- Stores a partial tag and a CTR_BITS-wide saturating counter per slot, for INSTR_PER_FETCH slots per row.
- Serves all slots' predictions per fetch; clears with a multi-cycle flush sweep instead of a single-cycle wipe.
- Sits beside the BTB and is read by the frontend every cycle.

---
 rtl/bht_tagged_sat.sv | 209 ++++++++++++++++++++
 tb/tb_bht_tagged_sat.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bht_tagged_sat.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : bht_tagged_sat                                              |
// | Purpose  : Tagged branch history table with saturating counters.      |
// |            Each row holds INSTR_PER_FETCH slots of {valid, tag, ctr}. |
// |            All slots of the fetched row are predicted every cycle.    |
// |            Flush is a row-by-row sweep that takes NR_ROWS cycles.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module bht_tagged_sat #(
  parameter int NR_ENTRIES      = 1024,
  parameter int INSTR_PER_FETCH = 2,
  parameter int CTR_BITS        = 2,
  parameter int TAG_BITS        = 8,
  parameter int VLEN            = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic                       flush_busy_o
);

  // ------------------------------------------------------------------------
  // Geometry. PCs are halfword aligned, so bit 0 never selects anything.
  // ------------------------------------------------------------------------
  localparam int NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int OFFSET  = 1;
  localparam int RB      = $clog2(INSTR_PER_FETCH);
  localparam int IB      = $clog2(NR_ROWS);
  localparam int SLOT_W  = (RB > 0) ? RB : 1;
  localparam int ROW_LSB = RB + OFFSET;
  localparam int TAG_LSB = IB + RB + OFFSET;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  // Freshly allocated entries start weakly taken (only the MSB set).
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [IB-1:0]       LAST_ROW = IB'(NR_ROWS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  state_e              state_q;
  logic [IB-1:0]       ptr_q;
  logic                busy_q;

  logic                valid_q [NR_ROWS][INSTR_PER_FETCH];
  logic [TAG_BITS-1:0] tag_q   [NR_ROWS][INSTR_PER_FETCH];
  logic [CTR_BITS-1:0] ctr_q   [NR_ROWS][INSTR_PER_FETCH];

  // ------------------------------------------------------------------------
  // Address decode for the fetch and update ports
  // ------------------------------------------------------------------------
  logic [IB-1:0]       pred_row;
  logic [TAG_BITS-1:0] pred_tag;
  logic [IB-1:0]       upd_row;
  logic [TAG_BITS-1:0] upd_tag;
  logic [SLOT_W-1:0]   upd_slot;

  assign pred_row = vpc_i[ROW_LSB +: IB];
  assign pred_tag = vpc_i[TAG_LSB +: TAG_BITS];
  assign upd_row  = upd_pc_i[ROW_LSB +: IB];
  assign upd_tag  = upd_pc_i[TAG_LSB +: TAG_BITS];

  generate
    if (RB > 0) begin : g_slot_idx
      assign upd_slot = upd_pc_i[OFFSET +: SLOT_W];
    end else begin : g_slot_zero
      // One slot per row: every update lands in slot 0.
      assign upd_slot = '0;
    end
  endgenerate

  // Address bits above the tag and the alignment bit carry no information
  // for this table; fold them into a sink so the ports stay fully consumed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i, upd_pc_i};

  // ------------------------------------------------------------------------
  // Update path: look up the addressed entry and form its next value
  // ------------------------------------------------------------------------
  logic                cur_valid;
  logic [TAG_BITS-1:0] cur_tag;
  logic [CTR_BITS-1:0] cur_ctr;
  logic                upd_en;
  logic                upd_hit;
  logic                upd_write;
  logic [CTR_BITS-1:0] ctr_d;

  assign cur_valid = valid_q[upd_row][upd_slot];
  assign cur_tag   = tag_q[upd_row][upd_slot];
  assign cur_ctr   = ctr_q[upd_row][upd_slot];

  // Updates only land while idle, outside debug mode, and never in the same
  // cycle a flush is requested (the flush wins and the update is lost).
  assign upd_en    = upd_valid_i && !debug_mode_i && (state_q == S_IDLE) && !flush_i;
  assign upd_hit   = cur_valid && (cur_tag == upd_tag);
  // A not-taken miss leaves the table alone; everything else writes.
  assign upd_write = upd_en && (upd_hit || upd_taken_i);

  // Saturating counter step on a hit, weakly-taken seed on an allocation.
  always_comb begin
    ctr_d = cur_ctr;
    if (upd_hit) begin
      if (upd_taken_i) begin
        if (cur_ctr != CTR_MAX) begin
          ctr_d = cur_ctr + 1'b1;
        end
      end else begin
        if (cur_ctr != '0) begin
          ctr_d = cur_ctr - 1'b1;
        end
      end
    end else begin
      ctr_d = CTR_WEAK;
    end
  end

  // ------------------------------------------------------------------------
  // Flush sequencer
  // ------------------------------------------------------------------------
  // Idle/flush control with the sweep pointer and a registered busy flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            state_q <= S_FLUSH;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_i) begin
            // A new request restarts the sweep from the first row.
            ptr_q <= '0;
          end else if (ptr_q == LAST_ROW) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flush_busy_o = busy_q;

  // ------------------------------------------------------------------------
  // Entry storage
  // ------------------------------------------------------------------------
  // Reset wipes everything; the sweep invalidates one row per cycle;
  // otherwise an accepted update rewrites the addressed slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR_ROWS; r++) begin
        for (int s = 0; s < INSTR_PER_FETCH; s++) begin
          valid_q[r][s] <= 1'b0;
          tag_q[r][s]   <= '0;
          ctr_q[r][s]   <= '0;
        end
      end
    end else if (state_q == S_FLUSH) begin
      for (int s = 0; s < INSTR_PER_FETCH; s++) begin
        valid_q[ptr_q][s] <= 1'b0;
      end
    end else if (upd_write) begin
      valid_q[upd_row][upd_slot] <= 1'b1;
      tag_q[upd_row][upd_slot]   <= upd_tag;
      ctr_q[upd_row][upd_slot]   <= ctr_d;
    end
  end

  // ------------------------------------------------------------------------
  // Prediction: purely combinational from the stored row, masked in flush
  // ------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_pred
      logic slot_hit;
      assign slot_hit        = valid_q[pred_row][i] && (tag_q[pred_row][i] == pred_tag) && !busy_q;
      assign pred_valid_o[i] = slot_hit;
      assign pred_taken_o[i] = slot_hit && ctr_q[pred_row][i][CTR_BITS-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bht_tagged_sat.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_bht_tagged_sat                                           |
// | Purpose  : Directed, self-checking bench for bht_tagged_sat with       |
// |            16 entries, 2 slots/row, 2-bit counters, 4-bit tags.        |
// |            Fields: slot = pc[1], row = pc[4:2], tag = pc[8:5].         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_bht_tagged_sat;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        debug_mode_i = 1'b0;
  logic [63:0] vpc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [1:0]  pred_valid_o;
  logic [1:0]  pred_taken_o;
  logic        flush_busy_o;

  int n_vec  = 0;
  int n_miss = 0;
  int cnt;

  bht_tagged_sat #(
    .NR_ENTRIES      (16),
    .INSTR_PER_FETCH (2),
    .CTR_BITS        (2),
    .TAG_BITS        (4),
    .VLEN            (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .debug_mode_i (debug_mode_i),
    .vpc_i        (vpc_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .flush_busy_o (flush_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = tk;
    tick();
    upd_valid_i = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic [63:0] pc,
                             input logic [1:0] v, input logic [1:0] t);
    vpc_i = pc;
    #1;
    check({tag, " valid"}, {30'd0, pred_valid_o}, {30'd0, v});
    check({tag, " taken"}, {30'd0, pred_taken_o}, {30'd0, t});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    tick();
    expect_pred("reset", 64'h0, 2'b00, 2'b00);
    check("reset busy", {31'd0, flush_busy_o}, 32'd0);

    // ---------------- allocate and count (0x126: row1 slot1 tag9) -------
    upd(64'h126, 1'b1);                               // ctr 2
    expect_pred("alloc", 64'h124, 2'b10, 2'b10);
    upd(64'h126, 1'b1);                               // ctr 3
    upd(64'h126, 1'b1);                               // ctr 3 (saturated)
    upd(64'h126, 1'b0);                               // ctr 2
    expect_pred("top sat", 64'h124, 2'b10, 2'b10);
    upd(64'h126, 1'b0);                               // ctr 1
    expect_pred("ctr1", 64'h124, 2'b10, 2'b00);
    upd(64'h126, 1'b0);                               // ctr 0
    upd(64'h126, 1'b0);                               // ctr 0 (saturated)
    expect_pred("bot sat", 64'h124, 2'b10, 2'b00);
    upd(64'h126, 1'b1);                               // ctr 1
    expect_pred("up from 0", 64'h124, 2'b10, 2'b00);
    upd(64'h126, 1'b1);                               // ctr 2
    expect_pred("up to 2", 64'h124, 2'b10, 2'b10);

    // bit 9 is above the tag: 0x324 aliases onto the same row/tag
    expect_pred("alias", 64'h324, 2'b10, 2'b10);

    // ---------------- tag mismatch and retag (0x026: row1 slot1 tag1) ---
    expect_pred("tag miss", 64'h024, 2'b00, 2'b00);
    upd(64'h026, 1'b0);                               // not-taken miss: ignored
    expect_pred("nt miss", 64'h024, 2'b00, 2'b00);
    expect_pred("nt keep", 64'h124, 2'b10, 2'b10);
    tick();
    upd(64'h026, 1'b1);                               // retag slot1 -> tag1
    expect_pred("old tag", 64'h124, 2'b00, 2'b00);
    expect_pred("retag", 64'h024, 2'b10, 2'b10);
    upd(64'h024, 1'b1);                               // slot0 of row1, tag1
    expect_pred("both slots", 64'h024, 2'b11, 2'b11);

    // ---------------- debug mode suppresses updates (0xA2: row0 slot1 tag5)
    debug_mode_i = 1'b1;
    upd(64'h0A2, 1'b1);
    debug_mode_i = 1'b0;
    expect_pred("debug", 64'h0A0, 2'b00, 2'b00);
    upd(64'h0A2, 1'b1);
    expect_pred("nodebug", 64'h0A0, 2'b10, 2'b10);

    // ---------------- fill every row with tag 3, both slots ----------------
    for (int r = 0; r < 8; r++) begin
      upd(64'h60 | (64'(r) << 2) | 64'h2, 1'b1);
      upd(64'h60 | (64'(r) << 2), 1'b1);
    end
    for (int r = 0; r < 8; r++) begin
      expect_pred("filled", 64'h60 | (64'(r) << 2), 2'b11, 2'b11);
      tick();
    end

    // ---------------- single flush pulse ----------------
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && flush_busy_o; c++) begin
      cnt++;
      // row 7 is cleared last; the busy mask must still hide it
      expect_pred("sweep mask", 64'h7C, 2'b00, 2'b00);
      if (cnt == 3) begin
        upd_valid_i = 1'b1;                           // row0 already swept
        upd_pc_i    = 64'hC2;
        upd_taken_i = 1'b1;
      end
      tick();
      upd_valid_i = 1'b0;
    end
    check("sweep len", cnt, 32'd8);
    for (int r = 0; r < 8; r++) begin
      expect_pred("swept", 64'h60 | (64'(r) << 2), 2'b00, 2'b00);
      tick();
    end
    expect_pred("drop in flush", 64'hC0, 2'b00, 2'b00);

    // ---------------- restart at sweep cycle 5 ----------------
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && flush_busy_o; c++) begin
      cnt++;
      if (cnt == 5) flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
    end
    check("restart len", cnt, 32'd13);

    // ---------------- asynchronous reset mid-sweep ----------------
    upd(64'h7E, 1'b1);                                // row7 slot1 tag3
    expect_pred("pre reset", 64'h7C, 2'b10, 2'b10);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    tick();
    check("mid sweep busy", {31'd0, flush_busy_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async rst busy", {31'd0, flush_busy_o}, 32'd0);
    expect_pred("in reset", 64'h7C, 2'b00, 2'b00);
    #1;
    rst_i = 1'b0;
    tick();
    check("post rst busy", {31'd0, flush_busy_o}, 32'd0);
    expect_pred("post rst", 64'h7C, 2'b00, 2'b00);
    tick();
    upd(64'h126, 1'b1);
    expect_pred("post rst alloc", 64'h124, 2'b10, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
